// File: rtl/game_pkg.sv
// Shared encodings for the turn scheduler: phase codes, winner codes, fixed colours.
package game_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_PLAYER  = 4'b0010,
    ST_RESOLVE = 4'b0100,
    ST_ENEMY   = 4'b1000,
    ST_OVER    = 4'b1111
  } state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_ENEMY  = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

  localparam logic [11:0] IDLE_COLOUR = 12'h000;
  localparam logic [11:0] OVER_COLOUR = 12'hF00;

  localparam logic [3:0] TURN_CEIL = 4'd15;

  // Turn limit must fit the 4-bit turn counter and leave at least one turn.
  function automatic logic [3:0] clamp_turns(input int unsigned n);
    if (n > 32'd15) return TURN_CEIL;
    if (n < 32'd1) return 4'd1;
    return n[3:0];
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase watchdog: down-counter reloaded on phase entry, expires at terminal count.
module phase_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] count;

  // Loading CYCLES-1 on entry makes the last in-phase cycle the CYCLES-th one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/turn_scheduler.sv
// Turn-based game phase scheduler (player, enemy, resolve) with turn limit and winner.
// Optional per-phase watchdog enabled by defining TURN_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start_in
// PLAYER  | player acting; player_start_out on entry
// ENEMY   | enemy acting; enemy_start_out on entry
// RESOLVE | one cycle: deaths / turn limit decide outcome
// OVER    | winner held until start_in
module turn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned MAX_TURNS      = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic        player_done_in,
  input  logic        enemy_busy_in,
  input  logic        enemy_finished_in,
  input  logic        player_dead_in,
  input  logic        enemy_dead_in,
  input  logic [11:0] player_pixel_in,
  input  logic [11:0] enemy_pixel_in,
  output logic [3:0]  state_out,
  output logic [3:0]  turn_out,
  output logic        player_start_out,
  output logic        enemy_start_out,
  output logic [1:0]  winner_out,
  output logic [11:0] pixel_out
);

  localparam logic [3:0] TURN_LIMIT = clamp_turns(MAX_TURNS);

  state_t state;
  state_t next_state;
  logic   first_cycle;
  logic   phase_entry;
  logic   timeout;

  assign phase_entry = (next_state != state);

  // Enemy completion is taken from enemy_finished_in alone; busy is informational.
  logic unused_busy;
  assign unused_busy = enemy_busy_in;

`ifdef TURN_TIMEOUT_EN
  logic timer_clear;
  logic timer_enable;

  assign timer_clear  = phase_entry && ((next_state == ST_PLAYER) || (next_state == ST_ENEMY));
  assign timer_enable = (state == ST_PLAYER) || (state == ST_ENEMY);

  phase_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      first_cycle <= 1'b0;
    end else begin
      state       <= next_state;
      first_cycle <= phase_entry;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start_in) next_state = ST_PLAYER;
      ST_PLAYER:  if ((player_done_in && !first_cycle) || timeout) next_state = ST_ENEMY;
      ST_ENEMY:   if (enemy_finished_in || timeout) next_state = ST_RESOLVE;
      ST_RESOLVE: begin
        if (player_dead_in || enemy_dead_in || (turn_out == TURN_LIMIT)) next_state = ST_OVER;
        else next_state = ST_PLAYER;
      end
      ST_OVER:    if (start_in) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    state_out        = state;
    player_start_out = first_cycle && (state == ST_PLAYER);
    enemy_start_out  = first_cycle && (state == ST_ENEMY);
  end

  // Turn count, verdict and pixel mux are registered alongside the phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      turn_out   <= 4'd0;
      winner_out <= WIN_NONE;
      pixel_out  <= IDLE_COLOUR;
    end else begin
      if ((state == ST_IDLE) && start_in) begin
        turn_out   <= 4'd1;
        winner_out <= WIN_NONE;
      end else if (state == ST_RESOLVE) begin
        if (player_dead_in) winner_out <= WIN_ENEMY;
        else if (enemy_dead_in) winner_out <= WIN_PLAYER;
        else if (turn_out == TURN_LIMIT) winner_out <= WIN_DRAW;
        else if (turn_out != TURN_CEIL) turn_out <= turn_out + 4'd1;
      end

      case (state)
        ST_ENEMY:             pixel_out <= enemy_pixel_in;
        ST_PLAYER, ST_RESOLVE: pixel_out <= player_pixel_in;
        ST_OVER:              pixel_out <= OVER_COLOUR;
        default:              pixel_out <= IDLE_COLOUR;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: directed scenarios plus a randomized game
// checked against a phase-level model of the game rules.
module tb_turn_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in, player_done_in, enemy_busy_in, enemy_finished_in;
  logic        player_dead_in, enemy_dead_in;
  logic [11:0] player_pixel_in, enemy_pixel_in;

  logic [3:0]  state_a, turn_a, state_b, turn_b;
  logic        pstart_a, estart_a, pstart_b, estart_b;
  logic [1:0]  win_a, win_b;
  logic [11:0] pix_a, pix_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  turn_scheduler dut (
    .clk(clk), .rst(rst), .start_in(start_in), .player_done_in(player_done_in),
    .enemy_busy_in(enemy_busy_in), .enemy_finished_in(enemy_finished_in),
    .player_dead_in(player_dead_in), .enemy_dead_in(enemy_dead_in),
    .player_pixel_in(player_pixel_in), .enemy_pixel_in(enemy_pixel_in),
    .state_out(state_a), .turn_out(turn_a), .player_start_out(pstart_a),
    .enemy_start_out(estart_a), .winner_out(win_a), .pixel_out(pix_a)
  );

  turn_scheduler #(.MAX_TURNS(2), .TIMEOUT_CYCLES(16)) dut2 (
    .clk(clk), .rst(rst), .start_in(start_in), .player_done_in(player_done_in),
    .enemy_busy_in(enemy_busy_in), .enemy_finished_in(enemy_finished_in),
    .player_dead_in(player_dead_in), .enemy_dead_in(enemy_dead_in),
    .player_pixel_in(player_pixel_in), .enemy_pixel_in(enemy_pixel_in),
    .state_out(state_b), .turn_out(turn_b), .player_start_out(pstart_b),
    .enemy_start_out(estart_b), .winner_out(win_b), .pixel_out(pix_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_in = 0; player_done_in = 0; enemy_busy_in = 0; enemy_finished_in = 0;
    player_dead_in = 0; enemy_dead_in = 0; player_pixel_in = '0; enemy_pixel_in = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    step();
    rst = 1;
    step();
  endtask

  task automatic start_game();
    start_in = 1;
    step();
    start_in = 0;
  endtask

  // Called on the PLAYER entry cycle; returns with RESOLVE visible.
  task automatic run_to_resolve();
    step();
    player_done_in = 1;
    step();
    player_done_in = 0;
    enemy_finished_in = 1;
    step();
    enemy_finished_in = 0;
  endtask

  function automatic logic [3:0] code_of(input int p);
    case (p)
      0: return 4'b0001;
      1: return 4'b0010;
      2: return 4'b1000;
      3: return 4'b0100;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (state_a !== 4'b0001) begin fails++; $display("FAIL reset_state got %b exp 0001", state_a); end
    tests++; if (turn_a !== 4'd0) begin fails++; $display("FAIL reset_turn got %0d exp 0", turn_a); end
    tests++; if ({pstart_a, estart_a} !== 2'b00) begin fails++; $display("FAIL reset_pulses got %b exp 00", {pstart_a, estart_a}); end
    tests++; if (win_a !== 2'b00) begin fails++; $display("FAIL reset_winner got %b exp 00", win_a); end
    tests++; if (pix_a !== 12'h000) begin fails++; $display("FAIL reset_pixel got %h exp 000", pix_a); end
    rst = 1;
    step();
    tests++; if (state_a !== 4'b0001) begin fails++; $display("FAIL reset_wait_idle got %b exp 0001", state_a); end
  endtask

  task automatic test_basic();
    int pulses;
    do_reset();
    start_game();
    tests++; if (state_a !== 4'b0010 || pstart_a !== 1'b1) begin fails++; $display("FAIL basic_player_entry got st=%b ps=%b exp 0010/1", state_a, pstart_a); end
    pulses = 0;
    // player_done_in in the entry cycle must be ignored
    player_done_in = 1;
    for (int i = 0; i < 3; i++) begin
      pulses += int'(pstart_a);
      step();
      player_done_in = 0;
    end
    tests++; if (state_a !== 4'b0010) begin fails++; $display("FAIL basic_still_player got %b exp 0010", state_a); end
    pulses += int'(pstart_a);
    player_done_in = 1;
    step();
    player_done_in = 0;
    tests++; if (pulses != 1) begin fails++; $display("FAIL basic_player_pulses got %0d exp 1", pulses); end
    tests++; if (state_a !== 4'b1000 || estart_a !== 1'b1) begin fails++; $display("FAIL basic_enemy_entry got st=%b es=%b exp 1000/1", state_a, estart_a); end
    step();
    tests++; if (state_a !== 4'b1000 || estart_a !== 1'b0) begin fails++; $display("FAIL basic_enemy_one_pulse got st=%b es=%b exp 1000/0", state_a, estart_a); end
  endtask

  task automatic test_three_turns();
    do_reset();
    start_game();
    for (int t = 1; t <= 4; t++) begin
      tests++; if (state_a !== 4'b0010 || turn_a !== 4'(t)) begin fails++; $display("FAIL turns_player got st=%b turn=%0d exp 0010/%0d", state_a, turn_a, t); end
      if (t == 4) break;
      step();
      player_done_in = 1;
      step();
      player_done_in = 0;
      tests++; if (state_a !== 4'b1000) begin fails++; $display("FAIL turns_enemy got %b exp 1000", state_a); end
      enemy_busy_in = 1;
      step();
      enemy_busy_in = 0;
      enemy_finished_in = 1;
      step();
      enemy_finished_in = 0;
      tests++; if (state_a !== 4'b0100) begin fails++; $display("FAIL turns_resolve got %b exp 0100", state_a); end
      step();
    end
  endtask

  task automatic test_both_dead();
    do_reset();
    start_game();
    run_to_resolve();
    player_dead_in = 1;
    enemy_dead_in = 1;
    step();
    player_dead_in = 0;
    enemy_dead_in = 0;
    tests++; if (state_a !== 4'b1111 || win_a !== 2'b10) begin fails++; $display("FAIL both_dead got st=%b win=%b exp 1111/10", state_a, win_a); end
    player_done_in = 1;
    enemy_finished_in = 1;
    step(); step();
    player_done_in = 0;
    enemy_finished_in = 0;
    tests++; if (state_a !== 4'b1111 || win_a !== 2'b10) begin fails++; $display("FAIL over_hold got st=%b win=%b exp 1111/10", state_a, win_a); end
    tests++; if (pix_a !== 12'hF00) begin fails++; $display("FAIL over_pixel got %h exp F00", pix_a); end
    start_game();
    tests++; if (state_a !== 4'b0001) begin fails++; $display("FAIL over_to_idle got %b exp 0001", state_a); end
  endtask

  task automatic test_draw();
    do_reset();
    start_game();
    run_to_resolve();
    step();
    tests++; if (state_b !== 4'b0010 || turn_b !== 4'd2) begin fails++; $display("FAIL draw_turn2 got st=%b turn=%0d exp 0010/2", state_b, turn_b); end
    run_to_resolve();
    tests++; if (state_b !== 4'b0100) begin fails++; $display("FAIL draw_resolve got %b exp 0100", state_b); end
    step();
    tests++; if (state_b !== 4'b1111 || win_b !== 2'b11) begin fails++; $display("FAIL draw_over got st=%b win=%b exp 1111/11", state_b, win_b); end
    step();
    tests++; if (turn_b !== 4'd2) begin fails++; $display("FAIL draw_turn_hold got %0d exp 2", turn_b); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_game();
    step();
    player_done_in = 1;
    step();
    player_done_in = 0;
    enemy_busy_in = 1;
    step();
    #2 rst = 0;
    #1;
    tests++; if (state_a !== 4'b0001 || {pstart_a, estart_a} !== 2'b00 || turn_a !== 4'd0 || win_a !== 2'b00 || pix_a !== 12'h000)
      begin fails++; $display("FAIL reset_mid_async got st=%b pulses=%b turn=%0d win=%b pix=%h exp 0001/00/0/00/000", state_a, {pstart_a, estart_a}, turn_a, win_a, pix_a); end
    step();
    tests++; if (state_a !== 4'b0001 || estart_a !== 1'b0) begin fails++; $display("FAIL reset_mid_edge got st=%b es=%b exp 0001/0", state_a, estart_a); end
    rst = 1;
    enemy_finished_in = 1;
    step(); step();
    enemy_finished_in = 0;
    enemy_busy_in = 0;
    tests++; if (state_a !== 4'b0001 || estart_a !== 1'b0) begin fails++; $display("FAIL reset_mid_ignore got st=%b es=%b exp 0001/0", state_a, estart_a); end
  endtask

`ifdef TURN_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    do_reset();
    start_game();
    tests++; if (state_b !== 4'b0010) begin fails++; $display("FAIL timeout_entry got %b exp 0010", state_b); end
    seen = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (state_b == 4'b1000) begin
        seen = i;
        break;
      end
    end
    tests++; if (seen != 16) begin fails++; $display("FAIL timeout_cycles got %0d exp 16", seen); end
    tests++; if (estart_b !== 1'b1) begin fails++; $display("FAIL timeout_enemy_pulse got %b exp 1", estart_b); end
  endtask
`endif

  // Phase model: 0 idle, 1 player, 2 enemy, 3 resolve, 4 over.
  task automatic test_random();
    int          ph, np, turn, nturn;
    logic [1:0]  win, nwin;
    logic [11:0] pix;
    logic        entry;
    int          errs;
    do_reset();
    ph = 0; turn = 0; win = 2'b00; pix = 12'h000; entry = 0; errs = 0;
    for (int c = 0; c < 3000; c++) begin
      tests++;
      if (state_a !== code_of(ph) || turn_a !== 4'(turn) || win_a !== win || pix_a !== pix ||
          pstart_a !== (ph == 1 && entry) || estart_a !== (ph == 2 && entry)) begin
        fails++;
        if (errs < 10) $display("FAIL random_cycle%0d got st=%b turn=%0d win=%b pix=%h ps=%b es=%b exp st=%b turn=%0d win=%b pix=%h",
                                c, state_a, turn_a, win_a, pix_a, pstart_a, estart_a, code_of(ph), turn, win, pix);
        errs++;
      end
      start_in          = ($urandom_range(0, 7) == 0);
      player_done_in    = ($urandom_range(0, 3) == 0);
      enemy_finished_in = ($urandom_range(0, 3) == 0);
      enemy_busy_in     = $urandom_range(0, 1) == 1;
      player_dead_in    = ($urandom_range(0, 5) == 0);
      enemy_dead_in     = ($urandom_range(0, 5) == 0);
      player_pixel_in   = 12'($urandom);
      enemy_pixel_in    = 12'($urandom);
      np = ph; nturn = turn; nwin = win;
      case (ph)
        0: if (start_in) begin np = 1; nturn = 1; nwin = 2'b00; end
        1: if (player_done_in && !entry) np = 2;
        2: if (enemy_finished_in) np = 3;
        3: begin
          if (player_dead_in) begin np = 4; nwin = 2'b10; end
          else if (enemy_dead_in) begin np = 4; nwin = 2'b01; end
          else if (turn == 15) begin np = 4; nwin = 2'b11; end
          else begin np = 1; nturn = turn + 1; end
        end
        default: if (start_in) np = 0;
      endcase
      if (ph == 2) pix = enemy_pixel_in;
      else if (ph == 1 || ph == 3) pix = player_pixel_in;
      else if (ph == 4) pix = 12'hF00;
      else pix = 12'h000;
      entry = (np != ph);
      ph = np; turn = nturn; win = nwin;
      step();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    #1;
    test_reset();
    test_basic();
    test_three_turns();
    test_both_dead();
    test_draw();
    test_reset_mid();
`ifdef TURN_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
